cspi_cmd: RTL
=============

# cspi_cmd

Command/register-access engine downstream of the ARM control-SPI slave. Consumes received bytes (`ctrl_data`/`ctrl_dvld`) and decodes them into register-bus reads and writes with address auto-increment. Returns read data as `ctrl_q`/`ctrl_qvld` so the SPI slave can shift it out on the following byte. Frames are delimited by an idle timeout, because the SPI slave exports no chip-select to this block.

## Interface
- `AW`, 7: register address width; equals command-byte bits [6:0].
- `IDLE_TMO`, 20'd1_000_000: `clk_sys` cycles with no `ctrl_dvld` before the frame is closed (10 ms at 100 MHz).
- `RD_TMO`, 8'd64: `clk_sys` cycles to wait for `reg_rvld` before returning a substitute byte.
- `RD_ERR`, 8'hEE: byte returned on read timeout.

- `clk_sys` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `ctrl_data` in 8: byte received from the SPI slave.
- `ctrl_dvld` in 1: one-cycle strobe; `ctrl_data` is valid in the same cycle.
- `ctrl_q` out 8: byte for the SPI slave to transmit next.
- `ctrl_qvld` out 1: one-cycle strobe loading `ctrl_q` into the SPI slave.
- `reg_addr` out AW: register address.
- `reg_wdata` out 8: write data.
- `reg_wr` out 1: one-cycle write strobe.
- `reg_rd` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data.
- `reg_rvld` in 1: read data valid; single cycle, arriving 1 or more cycles after `reg_rd`.
- `frame_act` out 1: high while a frame is open (any state other than IDLE).

## Operation
- **Command byte.** The first byte of a frame is `{rw, addr[6:0]}`; `rw` = 1 means read.
- **Write frame.** Each following byte is written to `addr`, then `addr+1`, and so on. Addresses wrap modulo 2^AW: 7'h7F is followed by 7'h00.
- **Read frame.**
  - The command byte itself triggers a read of `addr`.
  - The returned data goes out on `ctrl_q` and is transmitted during the next SPI byte.
  - Each following (dummy) byte received triggers a read of the next incremented address. Dummy byte contents are ignored.
- **States:**
  - IDLE: on `ctrl_dvld`, latch the address. If `rw`=0 go to WR. If `rw`=1 go to RD_REQ.
  - WR: on `ctrl_dvld`, pulse `reg_wr` with `reg_wdata=ctrl_data` and the current `reg_addr`, then increment the address on the next cycle. Stay in WR.
  - RD_REQ: pulse `reg_rd` for one cycle, then go to RD_WAIT.
  - RD_WAIT:
    - On `reg_rvld`: set `ctrl_q=reg_rdata`, pulse `ctrl_qvld`, increment the address, go to RD_HOLD.
    - If `RD_TMO` cycles pass without `reg_rvld`: set `ctrl_q=RD_ERR`, pulse `ctrl_qvld`, increment the address, go to RD_HOLD.
  - RD_HOLD: on `ctrl_dvld` go to RD_REQ.
- **Idle timer.**
  - Cleared on every `ctrl_dvld` and while in IDLE.
  - When it reaches `IDLE_TMO` in WR or RD_HOLD, the FSM returns to IDLE and the address is cleared.
  - In RD_REQ and RD_WAIT the timer keeps counting. A timeout there also returns to IDLE and suppresses any pending `ctrl_qvld`.
- **`ctrl_dvld` during RD_REQ or RD_WAIT** (host clocked faster than the read returned): the byte is dropped, and a sticky `overrun` flag is set internally. The current read still completes. `overrun` clears in IDLE.
- **Late `reg_rvld`** arriving after a read timeout is ignored.
- **Counter widths.** The idle counter is 20 bits and the read-timeout counter is 8 bits. Both saturate and never wrap.

## Timing
- **Reset values:** `ctrl_q`=8'hFF, `ctrl_qvld`=0, `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0, `frame_act`=0; FSM in IDLE.
- **All outputs are registered.**
- **Write latency:** `reg_wr` is asserted in the cycle after `ctrl_dvld`. `reg_addr` and `reg_wdata` are stable in that cycle.
- **Read issue latency:** `reg_rd` is asserted 2 cycles after the `ctrl_dvld` that triggers the read (one cycle to RD_REQ, one cycle to pulse).
- **Read return latency:** `ctrl_qvld` is asserted 1 cycle after `reg_rvld`.
- **Reset mid-frame:** returns immediately to IDLE with all outputs at their reset values. No partial strobe may be emitted.
- **Simultaneous idle timeout and `ctrl_dvld`:** `ctrl_dvld` wins, the timer clears, and the frame stays open.
- **Back-to-back bytes:** `ctrl_dvld` may arrive every cycle in WR, and each byte produces one `reg_wr`.

## Test plan
- Write 0x05, 0xA1, 0xB2 (bytes 1 cycle apart) -> `reg_wr` twice: (0x05, 0xA1), then (0x06, 0xB2). Then idle `IDLE_TMO` cycles -> `frame_act` falls to 0.
- Read 0x85 with `reg_rdata`=0x3C returned 3 cycles after `reg_rd` -> `reg_rd` at addr 0x05. `ctrl_q`=0x3C with `ctrl_qvld` 1 cycle after `reg_rvld`. A dummy byte then reads 0x06.
- Write burst starting at 0x7F -> second write goes to 0x00 (wrap).
- Read with `reg_rvld` never asserted -> after 64 cycles `ctrl_q`=0xEE with `ctrl_qvld`=1. A late `reg_rvld` is ignored.
- `ctrl_dvld` arrives while in RD_WAIT -> byte dropped, no extra `reg_rd`, current read completes.
- `rst` asserted in the cycle between `ctrl_dvld` and `reg_wr` -> no `reg_wr` emitted, FSM in IDLE, `ctrl_q`=0xFF.

Source files
------------

// File: rtl/cspi_cmd_if.sv
// Byte stream from the control-SPI slave plus the register-access bus driven by cspi_cmd.
interface cspi_cmd_if #(
    parameter int unsigned AW = 7
);
    logic [7:0]    ctrl_data;
    logic          ctrl_dvld;
    logic [7:0]    ctrl_q;
    logic          ctrl_qvld;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_wr;
    logic          reg_rd;
    logic [7:0]    reg_rdata;
    logic          reg_rvld;
    logic          frame_act;
    logic          overrun;

    modport slave (
        input  ctrl_data, ctrl_dvld, reg_rdata, reg_rvld,
        output ctrl_q, ctrl_qvld, reg_addr, reg_wdata, reg_wr, reg_rd, frame_act, overrun
    );

    modport master (
        output ctrl_data, ctrl_dvld, reg_rdata, reg_rvld,
        input  ctrl_q, ctrl_qvld, reg_addr, reg_wdata, reg_wr, reg_rd, frame_act, overrun
    );
endinterface

// File: rtl/cspi_cmd.sv
// Decodes SPI command/data bytes into register reads and writes with address auto-increment.
// Frames close after an idle timeout since the SPI slave provides no chip-select.
module cspi_cmd #(
    parameter int unsigned AW       = 7,
    parameter logic [19:0] IDLE_TMO = 20'd1_000_000,
    parameter logic [7:0]  RD_TMO   = 8'd64,
    parameter logic [7:0]  RD_ERR   = 8'hEE
) (
    input  logic      clk_sys,
    input  logic      rst,
    cspi_cmd_if.slave bus_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [7:0]    q_q, q_d;
    logic          qvld_q, qvld_d;
    logic          act_q, act_d;
    logic [19:0]   idle_cnt_q, idle_cnt_d;
    logic [7:0]    rd_cnt_q, rd_cnt_d;
    logic          overrun_q, overrun_d;
    logic          idle_tmo;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            q_q        <= 8'hFF;
            qvld_q     <= 1'b0;
            act_q      <= 1'b0;
            idle_cnt_q <= 20'd0;
            rd_cnt_q   <= 8'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            q_q        <= q_d;
            qvld_q     <= qvld_d;
            act_q      <= act_d;
            idle_cnt_q <= idle_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        q_d        = q_q;
        qvld_d     = 1'b0;
        idle_cnt_d = idle_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        overrun_d  = overrun_q;

        // A received byte always beats a coincident idle timeout
        idle_tmo = (idle_cnt_q >= IDLE_TMO) && !bus_if.ctrl_dvld;

        if (state_q == S_IDLE || bus_if.ctrl_dvld) begin
            idle_cnt_d = 20'd0;
        end else if (idle_cnt_q != 20'hF_FFFF) begin
            idle_cnt_d = idle_cnt_q + 20'd1;
        end

        // The address advances in the cycle after each write strobe
        if (wr_q) begin
            addr_d = addr_q + AW'(1);
        end

        case (state_q)
            S_IDLE: begin
                overrun_d = 1'b0;
                if (bus_if.ctrl_dvld) begin
                    addr_d  = bus_if.ctrl_data[AW-1:0];
                    state_d = bus_if.ctrl_data[7] ? S_RD_REQ : S_WR;
                end
            end
            S_WR: begin
                if (bus_if.ctrl_dvld) begin
                    wr_d    = 1'b1;
                    wdata_d = bus_if.ctrl_data;
                end
            end
            S_RD_REQ: begin
                rd_d     = 1'b1;
                rd_cnt_d = 8'd0;
                state_d  = S_RD_WAIT;
                if (bus_if.ctrl_dvld) begin
                    overrun_d = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (bus_if.ctrl_dvld) begin
                    overrun_d = 1'b1;
                end
                if (bus_if.reg_rvld) begin
                    q_d     = bus_if.reg_rdata;
                    qvld_d  = 1'b1;
                    addr_d  = addr_q + AW'(1);
                    state_d = S_RD_HOLD;
                end else if (rd_cnt_q >= RD_TMO - 8'd1) begin
                    q_d     = RD_ERR;
                    qvld_d  = 1'b1;
                    addr_d  = addr_q + AW'(1);
                    state_d = S_RD_HOLD;
                end else if (rd_cnt_q != 8'hFF) begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                end
            end
            S_RD_HOLD: begin
                if (bus_if.ctrl_dvld) begin
                    state_d = S_RD_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame timeout overrides everything, including a read result about to be returned
        if (state_q != S_IDLE && idle_tmo) begin
            state_d = S_IDLE;
            addr_d  = '0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            qvld_d  = 1'b0;
            q_d     = q_q;
        end

        act_d = (state_d != S_IDLE);
    end

    assign bus_if.ctrl_q    = q_q;
    assign bus_if.ctrl_qvld = qvld_q;
    assign bus_if.reg_addr  = addr_q;
    assign bus_if.reg_wdata = wdata_q;
    assign bus_if.reg_wr    = wr_q;
    assign bus_if.reg_rd    = rd_q;
    assign bus_if.frame_act = act_q;
    assign bus_if.overrun   = overrun_q;

endmodule
